// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
// These cover the FSM state encoding, the datapath widths and the write-request bundle.
package wb_port_arbiter_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  localparam logic [REG_AW-1:0] X0 = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FORCE = 2'd2
  } arb_state_t;

  // One candidate write toward the register-file port.
  typedef struct packed {
    logic              wren;
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  localparam wr_req_t WR_NONE = '{wren: 1'b0, addr: '0, data: '0};

endpackage : wb_port_arbiter_pkg

// File: rtl/wb_pend_buffer.sv
// One-entry parking slot for an MDU result that lost the write port.
// The match output lets the arbiter squash the entry when a younger main write
// targets the same register.
module wb_pend_buffer
  import wb_port_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [REG_AW-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic [REG_AW-1:0] cmp_addr,
  output logic              valid,
  output logic [REG_AW-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              match
);

  // Capture on load, empty on clear; load wins if both are raised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: addr/data are reset along with valid so the exported pending
      // address is a clean 0 out of reset rather than X.
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (load) begin
      // NOTE: sequential state uses <= so every register samples pre-edge
      // values; a blocking = here would create ordering-dependent behaviour.
      valid <= 1'b1;
      addr  <= load_addr;
      data  <= load_data;
    end else if (clear) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end
  end

  // Same-register hit against the incoming main write.
  assign match = valid && (addr == cmp_addr);

endmodule : wb_pend_buffer

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between the main writeback path and the MDU.
// Main always wins. A colliding MDU result is parked and drained on the next
// free slot. If main keeps the port busy for STARVE_LIMIT cycles, the main
// pipeline is stalled for one cycle so the parked result can drain.
// STARVE_LIMIT must lie in 1..15.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_main_wren,
  input  logic [REG_AW-1:0] i_main_rd_addr,
  input  logic [DATA_W-1:0] i_main_rd_data,
  input  logic              i_mdu_valid,
  input  logic [REG_AW-1:0] i_mdu_rd_addr,
  input  logic [DATA_W-1:0] i_mdu_data,
  output logic              o_mdu_ready,
  output logic              o_stall_main,
  output logic              o_pend_valid,
  output logic [REG_AW-1:0] o_pend_addr,
  output logic              o_rd_wren,
  output logic [REG_AW-1:0] o_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  // The last HOLD count value that still lets main write. Reaching it with
  // another main write sends the FSM to FORCE.
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              main_wr;
  logic              mdu_acc;
  logic              mdu_live;
  logic              buf_load;
  logic              buf_clear;
  logic              buf_valid;
  logic [REG_AW-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;
  logic              buf_match;

  wr_req_t           main_req;
  wr_req_t           mdu_req;
  wr_req_t           buf_req;
  wr_req_t           port;

  // A write to x0 is architecturally a no-op, so it never claims the port.
  assign main_wr  = i_main_wren && (i_main_rd_addr != X0);
  assign mdu_acc  = i_mdu_valid && o_mdu_ready;
  // An accepted MDU result aimed at x0 is consumed but produces no write.
  assign mdu_live = mdu_acc && (i_mdu_rd_addr != X0);

  assign main_req = '{wren: 1'b1, addr: i_main_rd_addr, data: i_main_rd_data};
  assign mdu_req  = '{wren: 1'b1, addr: i_mdu_rd_addr,  data: i_mdu_data};
  assign buf_req  = '{wren: 1'b1, addr: buf_addr,       data: buf_data};

  wb_pend_buffer u_pend (
    .clk       (i_clk),
    .rst_n     (i_reset_n),
    .load      (buf_load),
    .clear     (buf_clear),
    .load_addr (i_mdu_rd_addr),
    .load_data (i_mdu_data),
    .cmp_addr  (i_main_rd_addr),
    .valid     (buf_valid),
    .addr      (buf_addr),
    .data      (buf_data),
    .match     (buf_match)
  );

  // State and starvation counter registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter and buffer control.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statement can leave one unassigned and infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    buf_load  = 1'b0;
    buf_clear = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // Park only a live result that collides with a different main rd.
        // A result to the same rd is dropped because the younger main write wins.
        if (main_wr && mdu_live && (i_mdu_rd_addr != i_main_rd_addr)) begin
          buf_load = 1'b1;
          state_d  = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (!main_wr || buf_match) begin
          // Drain into the free slot, or squash because main overwrites the same rd.
          buf_clear = 1'b1;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end else if (cnt_q == LIMIT_M1) begin
          cnt_d   = '0;
          state_d = ST_FORCE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_FORCE: begin
        buf_clear = 1'b1;
        cnt_d     = '0;
        state_d   = ST_IDLE;
      end

      default: begin
        buf_clear = 1'b1;
        cnt_d     = '0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // Port mux and handshake / hazard outputs.
  always_comb begin
    port         = WR_NONE;
    o_mdu_ready  = 1'b0;
    o_stall_main = 1'b0;
    o_pend_valid = 1'b0;
    o_pend_addr  = '0;

    unique case (state_q)
      ST_IDLE: begin
        o_mdu_ready = 1'b1;
        if (main_wr) begin
          port = main_req;
        end else if (mdu_live) begin
          port = mdu_req;
        end
      end

      ST_HOLD: begin
        o_pend_valid = buf_valid;
        o_pend_addr  = buf_valid ? buf_addr : X0;
        port         = main_wr ? main_req : buf_req;
      end

      ST_FORCE: begin
        // Main is frozen this cycle, so the parked result owns the port.
        o_stall_main = 1'b1;
        o_pend_valid = buf_valid;
        o_pend_addr  = buf_valid ? buf_addr : X0;
        port         = buf_req;
      end

      default: begin
        port = WR_NONE;
      end
    endcase
  end

  assign o_rd_wren = port.wren;
  assign o_rd_addr = port.wren ? port.addr : X0;
  assign o_rd_data = port.wren ? port.data : '0;

endmodule : wb_port_arbiter
